// File: rtl/aes_csr_shadow_monitor.sv
// Passive CSR monitor: keeps a byte-strobed shadow of the register file and checks in-order read data.
// Optional macro AES_CSR_MISMATCH_CNT_EN adds a saturating 16-bit mismatch counter output.
module aes_csr_shadow_monitor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 8,
  parameter int BASE_ADDR       = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic                                   req_write_i,
  input  logic [ADDR_WIDTH-1:0]                  req_addr_i,
  input  logic [DATA_WIDTH-1:0]                  req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]                req_wstrb_i,
  input  logic                                   rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                  rsp_rdata_i,
  output logic                                   mismatch_o,
  output logic [ADDR_WIDTH-1:0]                  mismatch_addr_o,
  output logic [DATA_WIDTH-1:0]                  expected_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_overflow_o,
  output logic                                   err_unexpected_rsp_o
`ifdef AES_CSR_MISMATCH_CNT_EN
  ,
  output logic [15:0]                            mismatch_cnt_o
`endif
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic [ADDR_WIDTH-1:0] r_q_addr [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] r_q_exp  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_mismatch;
  logic [ADDR_WIDTH-1:0] r_mismatch_addr;
  logic [DATA_WIDTH-1:0] r_expected;
  logic                  r_err_overflow;
  logic                  r_err_unexpected;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [IDX_W-1:0]      w_sel;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_shadow_wr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_exp;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_offset   = req_addr_i - ADDR_WIDTH'(BASE_ADDR);
  assign w_idx      = w_offset >> BYTE_SHIFT;
  assign w_sel      = w_idx[IDX_W-1:0];
  assign w_in_range = (req_addr_i >= ADDR_WIDTH'(BASE_ADDR)) && (w_idx < ADDR_WIDTH'(NUM_REGS));
  assign w_rd_val   = w_in_range ? r_shadow[w_sel] : '0;

  assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty     = (r_count == '0);
  assign req_ready_o = !rst_i && !w_full;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_push      = w_accept && !req_write_i;
  assign w_shadow_wr = w_accept && req_write_i && w_in_range;
  // An empty queue never pops, even if a read is being pushed this same cycle.
  assign w_pop       = rsp_valid_i && !w_empty;
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_exp  = r_q_exp[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) r_shadow[r] <= '0;
    end else if (w_shadow_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (req_wstrb_i[b]) r_shadow[w_sel][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  // Expected data is snapshotted at acceptance, so later writes cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= req_addr_i;
      r_q_exp[r_wr_ptr]  <= w_rd_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_mismatch       <= 1'b0;
      r_mismatch_addr  <= '0;
      r_expected       <= '0;
      r_err_overflow   <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      r_mismatch <= w_pop && (rsp_rdata_i != w_head_exp);
      if (w_pop && (rsp_rdata_i != w_head_exp)) begin
        r_mismatch_addr <= w_head_addr;
        r_expected      <= w_head_exp;
      end
      if (req_valid_i && w_full) r_err_overflow <= 1'b1;
      if (rsp_valid_i && w_empty) r_err_unexpected <= 1'b1;
    end
  end

  assign mismatch_o           = r_mismatch;
  assign mismatch_addr_o      = r_mismatch_addr;
  assign expected_o           = r_expected;
  assign outstanding_o        = r_count;
  assign err_overflow_o       = r_err_overflow;
  assign err_unexpected_rsp_o = r_err_unexpected;

`ifdef AES_CSR_MISMATCH_CNT_EN
  logic [15:0] r_mismatch_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch_cnt <= '0;
    end else if (r_mismatch && (r_mismatch_cnt != 16'hFFFF)) begin
      r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
    end
  end

  assign mismatch_cnt_o = r_mismatch_cnt;
`endif

endmodule

// File: tb/tb_aes_csr_shadow_monitor.sv
// Self-checking bench for aes_csr_shadow_monitor: directed scenarios plus randomized traffic vs a queue-based model.
module tb_aes_csr_shadow_monitor;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NREG = 8;
  localparam int BASE = 0;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [3:0]    req_wstrb_i;
  logic          rsp_valid_i;
  logic [DW-1:0] rsp_rdata_i;
  logic          mismatch_o;
  logic [AW-1:0] mismatch_addr_o;
  logic [DW-1:0] expected_o;
  logic [CW-1:0] outstanding_o;
  logic          err_overflow_o;
  logic          err_unexpected_rsp_o;
`ifdef AES_CSR_MISMATCH_CNT_EN
  logic [15:0]   mismatch_cnt_o;
`endif

  aes_csr_shadow_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
    .mismatch_o(mismatch_o), .mismatch_addr_o(mismatch_addr_o), .expected_o(expected_o),
    .outstanding_o(outstanding_o), .err_overflow_o(err_overflow_o),
    .err_unexpected_rsp_o(err_unexpected_rsp_o)
`ifdef AES_CSR_MISMATCH_CNT_EN
    , .mismatch_cnt_o(mismatch_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_shadow [NREG];
  logic        m_mm;
  logic [31:0] m_maddr;
  logic [31:0] m_mexp;
  logic        m_ovf;
  logic        m_unexp;
  int          m_cnt;
  int          n_vec;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < NREG);
  endfunction

  task automatic model_edge();
    bit   rdy;
    ent_t e;
    int   idx;
    if (rst_i) begin
      mq.delete();
      for (int r = 0; r < NREG; r++) m_shadow[r] = '0;
      m_mm = 0; m_maddr = '0; m_mexp = '0; m_ovf = 0; m_unexp = 0; m_cnt = 0;
    end else begin
      rdy = (mq.size() != MAXO);
      idx = in_range(req_addr_i) ? int'((req_addr_i - BASE) / 4) : -1;
      if (m_mm && m_cnt < 65535) m_cnt++;
      if (req_valid_i && !rdy) m_ovf = 1;
      m_mm = 0;
      if (rsp_valid_i) begin
        if (mq.size() == 0) m_unexp = 1;
        else begin
          e = mq.pop_front();
          if (rsp_rdata_i != e.exp) begin
            m_mm = 1; m_maddr = e.addr; m_mexp = e.exp;
          end
        end
      end
      if (req_valid_i && rdy && !req_write_i) begin
        e.addr = req_addr_i;
        e.exp  = (idx >= 0) ? m_shadow[idx] : 32'h0;
        mq.push_back(e);
      end
      if (req_valid_i && rdy && req_write_i && idx >= 0) begin
        for (int b = 0; b < 4; b++)
          if (req_wstrb_i[b]) m_shadow[idx][8*b +: 8] = req_wdata_i[8*b +: 8];
      end
    end
  endtask

  // Inputs are driven at the falling edge; ready is checked combinationally, the rest after the edge.
  task automatic step();
    #1;
    chk("ready", req_ready_o, (!rst_i && mq.size() != MAXO));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("mismatch", mismatch_o, m_mm);
    chk("mm_addr", mismatch_addr_o, m_maddr);
    chk("expected", expected_o, m_mexp);
    chk("outstanding", outstanding_o, mq.size());
    chk("err_ovf", err_overflow_o, m_ovf);
    chk("err_unexp", err_unexpected_rsp_o, m_unexp);
`ifdef AES_CSR_MISMATCH_CNT_EN
    chk("mm_cnt", mismatch_cnt_o, m_cnt);
`endif
  endtask

  task automatic idle();
    req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_wdata_i = '0;
    req_wstrb_i = '0; rsp_valid_i = 0; rsp_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; step(); rst_i = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    idle(); req_valid_i = 1; req_write_i = 1; req_addr_i = a; req_wdata_i = d; req_wstrb_i = s; step();
  endtask

  task automatic do_read(input logic [31:0] a);
    idle(); req_valid_i = 1; req_addr_i = a; step();
  endtask

  task automatic do_rsp(input logic [31:0] d);
    idle(); rsp_valid_i = 1; rsp_rdata_i = d; step();
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst_i = 1; idle();
    do_reset();
    chk("rst_outst", outstanding_o, 0);
    chk("rst_ovf", err_overflow_o, 0);
    chk("rst_unexp", err_unexpected_rsp_o, 0);
    chk("rst_mm", mismatch_o, 0);

    // Full-word write then matching read
    do_write(32'h4, 32'hDEADBEEF, 4'hF);
    do_read(32'h4);
    chk("t1_outst1", outstanding_o, 1);
    do_rsp(32'hDEADBEEF);
    chk("t1_mm", mismatch_o, 0);
    chk("t1_outst0", outstanding_o, 0);

    // Partial strobe write
    do_reset();
    do_write(32'h8, 32'h11223344, 4'h3);
    do_read(32'h8);
    do_rsp(32'h00003344);
    chk("t2_nomm", mismatch_o, 0);
    do_read(32'h8);
    do_rsp(32'h11223344);
    chk("t2_mm", mismatch_o, 1);
    chk("t2_addr", mismatch_addr_o, 32'h8);
    chk("t2_exp", expected_o, 32'h00003344);
    idle(); step();
    chk("t2_pulse", mismatch_o, 0);
    chk("t2_hold", mismatch_addr_o, 32'h8);

    // Queue full and overflow
    do_reset();
    for (int i = 0; i < 4; i++) do_read(32'h10);
    idle(); #1;
    chk("t3_notready", req_ready_o, 0);
    step();
    do_read(32'h10);
    chk("t3_ovf", err_overflow_o, 1);
    chk("t3_outst", outstanding_o, 4);
    do_rsp(32'h0);
    idle(); #1;
    chk("t3_ready", req_ready_o, 1);
    step();
    for (int i = 0; i < 3; i++) do_rsp(32'h0);
    chk("t3_drain", outstanding_o, 0);

    // Snapshot at acceptance
    do_write(32'hC, 32'hA5A5A5A5, 4'hF);
    do_read(32'hC);
    do_write(32'hC, 32'h0, 4'hF);
    do_rsp(32'hA5A5A5A5);
    chk("t4_nomm", mismatch_o, 0);

    // Unexpected response and out-of-range read
    do_rsp(32'h1);
    chk("t5_unexp", err_unexpected_rsp_o, 1);
    do_read(32'h100);
    do_rsp(32'h0);
    chk("t5_oor", mismatch_o, 0);
    chk("t5_sticky", err_unexpected_rsp_o, 1);

    // Reset discards pending reads
    do_reset();
    do_read(32'h0);
    do_read(32'h4);
    do_reset();
    chk("t6_outst", outstanding_o, 0);
    do_rsp(32'h12345678);
    chk("t6_mm", mismatch_o, 0);
    chk("t6_unexp", err_unexpected_rsp_o, 1);

    // Three back-to-back mismatches
    do_reset();
    for (int i = 0; i < 3; i++) do_read(32'h0);
    for (int i = 0; i < 3; i++) do_rsp(32'h1);
    chk("t7_mm", mismatch_o, 1);
    idle(); step();
`ifdef AES_CSR_MISMATCH_CNT_EN
    chk("t7_cnt", mismatch_cnt_o, 3);
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int sel;
      idle();
      rst_i = ($urandom_range(0, 299) == 0);
      req_valid_i = ($urandom_range(0, 9) < 5);
      req_write_i = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 8) req_addr_i = 32'(sel * 4 + $urandom_range(0, 3));
      else if (sel == 8) req_addr_i = 32'h100;
      else req_addr_i = $urandom;
      req_wdata_i = $urandom;
      req_wstrb_i = 4'($urandom_range(0, 15));
      rsp_valid_i = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) rsp_rdata_i = mq[0].exp;
      else rsp_rdata_i = $urandom;
      step();
    end
    rst_i = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_csr_shadow_monitor.md
Name: aes_csr_shadow_monitor

Overview:
Parametrised CSR bus monitor for the AES formal/simulation environment.
- Observes a valid/ready CSR request channel and a read-response channel.
- Keeps a byte-strobed shadow copy of NUM_REGS word registers.
- Queues the expected read data for up to MAX_OUTSTANDING pending reads.
- Flags read data that differs from the shadow, plus protocol errors.
- Sits beside the CSR checker on the AES register interface; it does not drive the DUT.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- NUM_REGS, 8, number of shadowed word registers; must be ≥2.
- BASE_ADDR, 0, byte address of register 0; word-aligned.
- MAX_OUTSTANDING, 4, depth of the pending-read queue; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  monitor can accept a request.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  DATA_WIDTH/8  byte write strobes.
- rsp_valid_i  in  1  read response valid.
- rsp_rdata_i  in  DATA_WIDTH  read response data.
- mismatch_o  out  1  one-cycle pulse on a read-data mismatch.
- mismatch_addr_o  out  ADDR_WIDTH  address of the mismatching read.
- expected_o  out  DATA_WIDTH  expected data of the mismatching read.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of pending reads.
- err_overflow_o  out  1  sticky error: request presented while the queue is full.
- err_unexpected_rsp_o  out  1  sticky error: response received with no pending read.

Behaviour:
- Reset (rst_i sampled high at a clk_i edge) clears:
  - the whole shadow array and the queue;
  - mismatch_o, mismatch_addr_o, expected_o, outstanding_o, and both error flags, all to 0.
  - Reset mid-operation discards all pending reads with no mismatch report.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o = (outstanding_o != MAX_OUTSTANDING). It is combinational and 0 during reset.
  - req_valid_i=1 while req_ready_o=0 sets err_overflow_o. The request is not accepted; the requester must hold it.
- Address decode:
  - idx = (req_addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - In range when req_addr_i >= BASE_ADDR and idx < NUM_REGS.
  - Low address bits are ignored.
- Accepted write:
  - In range: each shadow byte with its strobe set takes the req_wdata_i byte at the next edge.
  - Out of range: ignored.
- Accepted read:
  - Pushes {req_addr_i, expected} into the queue; outstanding_o increments at the next edge.
  - expected = shadow[idx] as of the acceptance cycle, or 0 when out of range.
  - A later write to the same register does not alter an already queued expectation.
- Response (rsp_valid_i=1):
  - With outstanding_o>0:
    - pops the queue head;
    - compares rsp_rdata_i with the head expected value;
    - on inequality, the next cycle has mismatch_o=1 and mismatch_addr_o/expected_o loaded from the head. These two hold until the next mismatch.
  - With outstanding_o=0: sets err_unexpected_rsp_o; no pop, no compare.
- Simultaneous accepted read and response in one cycle:
  - push and pop both occur; outstanding_o is unchanged;
  - the response compares against the old head;
  - when the queue is empty, the response is unexpected even if a read is accepted in the same cycle.
- Responses are in order. Depth-1 queue and wrap-around of the queue pointers must work for any MAX_OUTSTANDING.
- Sticky errors clear only on reset.

Optional Feature:
AES_CSR_MISMATCH_CNT_EN
- Defined:
  - adds output port mismatch_cnt_o [15:0], reset to 0;
  - increments on every cycle in which mismatch_o is asserted;
  - saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF to 0x4 (wstrb 0xF), then read 0x4; response 0xDEADBEEF -> mismatch_o stays 0; outstanding_o goes 1 then 0.
- Write 0x11223344 to 0x8 with wstrb 0x3 after a reset; read 0x8; response 0x00003344 -> no mismatch. Response 0x11223344 -> mismatch_o pulse, mismatch_addr_o=0x8, expected_o=0x00003344.
- Issue 4 reads back-to-back without responses (MAX_OUTSTANDING=4) -> req_ready_o=0 after the 4th; a 5th valid sets err_overflow_o=1. Then one response -> req_ready_o=1.
- Read 0xC (shadow 0xA5A5A5A5), then write 0x0 to 0xC, then respond 0xA5A5A5A5 -> no mismatch, because the snapshot is taken at acceptance.
- rsp_valid_i with outstanding_o=0 -> err_unexpected_rsp_o=1, sticky until rst_i. Read of out-of-range 0x100 with response 0x0 -> no mismatch.
- Queue 2 reads, assert rst_i for 1 cycle, then respond -> outstanding_o=0 after reset, no mismatch, err_unexpected_rsp_o=1. With AES_CSR_MISMATCH_CNT_EN, 3 forced mismatches -> mismatch_cnt_o=3.
